// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache controller.
// Holds address/line geometry, line field positions, the controller state
// enum and the packed line layout {valid, tag, data} as stored in the line RAM.
package icache_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned INDEX_W  = 10;
  localparam int unsigned OFFSET_W = 6;
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned WORDS    = 16;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BEAT_W   = $clog2(WORDS);
  localparam int unsigned DATA_W   = WORDS * WORD_W;
  localparam int unsigned LINE_W   = DATA_W + TAG_W + 1;
  localparam int unsigned LINES    = 1 << INDEX_W;

  // Field positions inside a stored line.
  localparam int unsigned VALID_BIT = LINE_W - 1;
  localparam int unsigned TAG_LSB   = DATA_W;
  localparam int unsigned TAG_MSB   = DATA_W + TAG_W - 1;

  typedef enum logic [2:0] {
    StFlush,
    StIdle,
    StLookup,
    StRefillReq,
    StRefillData,
    StWrite
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

endpackage

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction-cache controller in front of an external
// single-port line RAM (asynchronous read, synchronous write).
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_req_*, o_req_ready   fetch request handshake (byte address)
//   o_resp_valid/_data     one-cycle fetch response, no backpressure
//   i_flush, o_flush_busy  invalidate-all request and sweep-in-progress flag
//   o_mem_req_*, i_mem_*   line refill request and 16 ascending data beats
//   o_bram_*, i_bram_rdata line RAM write port and combinational read data
module icache_ctrl
  import icache_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              o_req_ready,
  output logic              o_resp_valid,
  output logic [WORD_W-1:0] o_resp_data,
  input  logic              i_flush,
  output logic              o_flush_busy,
  output logic              o_mem_req_valid,
  output logic [ADDR_W-1:0] o_mem_req_addr,
  input  logic              i_mem_req_ready,
  input  logic              i_mem_resp_valid,
  input  logic [WORD_W-1:0] i_mem_resp_data,
  output logic              o_bram_we,
  output logic [INDEX_W-1:0] o_bram_addr,
  output logic [LINE_W-1:0] o_bram_wdata,
  input  logic [LINE_W-1:0] i_bram_rdata
);

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:2]   r_addr;
  logic [INDEX_W-1:0]  r_sweep;
  logic [BEAT_W-1:0]   r_beat;
  logic [DATA_W-1:0]   r_line;
  logic                r_flush_pend;

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [BEAT_W-1:0]   w_word;
  line_t               w_rd_line;
  line_t               w_wline;
  logic                w_hit;
  logic                w_flush_req;
  logic                w_req_fire;
  logic                w_beat_fire;
  logic                w_enter_flush;
  logic                w_unused_addr_lsb;

  // Byte-within-word bits never matter for a word fetch.
  assign w_unused_addr_lsb = ^i_req_addr[1:0];

  assign w_tag       = r_addr[ADDR_W-1 -: TAG_W];
  assign w_index     = r_addr[OFFSET_W +: INDEX_W];
  assign w_word      = r_addr[2 +: BEAT_W];
  assign w_rd_line   = i_bram_rdata;
  assign w_hit       = w_rd_line.valid && (w_rd_line.tag == w_tag);
  // A flush seen this cycle counts as pending so it wins over a same-cycle request.
  assign w_flush_req = r_flush_pend | i_flush;
  assign w_req_fire  = i_req_valid && o_req_ready;
  assign w_beat_fire = (r_state == StRefillData) && i_mem_resp_valid;
  assign w_enter_flush = (r_state != StFlush) && (w_state_next == StFlush);

  always_comb begin
    w_state_next    = r_state;
    o_req_ready     = 1'b0;
    o_resp_valid    = 1'b0;
    o_resp_data     = '0;
    o_flush_busy    = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_req_addr  = '0;
    o_bram_we       = 1'b0;
    o_bram_addr     = '0;
    w_wline         = '0;
    unique case (r_state)
      StFlush: begin
        o_flush_busy = 1'b1;
        o_bram_we    = 1'b1;
        o_bram_addr  = r_sweep;
        if (r_sweep == '1) w_state_next = StIdle;
      end
      StIdle: begin
        if (w_flush_req) begin
          w_state_next = StFlush;
        end else begin
          o_req_ready = 1'b1;
          if (i_req_valid) w_state_next = StLookup;
        end
      end
      StLookup: begin
        o_bram_addr = w_index;
        if (w_hit) begin
          o_resp_valid = 1'b1;
          o_resp_data  = w_rd_line.data[{w_word, 5'd0} +: WORD_W];
          w_state_next = StIdle;
        end else begin
          w_state_next = StRefillReq;
        end
      end
      StRefillReq: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_addr  = {r_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        if (i_mem_req_ready) w_state_next = StRefillData;
      end
      StRefillData: begin
        if (w_beat_fire && (r_beat == BEAT_W'(WORDS - 1))) w_state_next = StWrite;
      end
      StWrite: begin
        w_wline.valid = 1'b1;
        w_wline.tag   = w_tag;
        w_wline.data  = r_line;
        o_bram_we     = 1'b1;
        o_bram_addr   = w_index;
        w_state_next  = StLookup;
      end
      default: w_state_next = StFlush;
    endcase
  end

  assign o_bram_wdata = w_wline;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StFlush;
      r_addr       <= '0;
      r_sweep      <= '0;
      r_beat       <= '0;
      r_line       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_req_fire) r_addr <= i_req_addr[ADDR_W-1:2];

      if (w_enter_flush) r_flush_pend <= 1'b0;
      else if (i_flush)  r_flush_pend <= 1'b1;

      if (w_enter_flush)           r_sweep <= '0;
      else if (r_state == StFlush) r_sweep <= r_sweep + 1'b1;

      if (r_state == StRefillReq) begin
        r_beat <= '0;
      end else if (w_beat_fire) begin
        r_line[{r_beat, 5'd0} +: WORD_W] <= i_mem_resp_data;
        r_beat <= r_beat + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: line RAM and memory responder models,
// a transparent-cache reference model (every fetch returns backing-memory data,
// miss/hit decided from a per-index tag table), and one compare process.
module tb_icache_ctrl;
  import icache_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic [ADDR_W-1:0]  req_addr;
  logic               req_ready;
  logic               resp_valid;
  logic [WORD_W-1:0]  resp_data;
  logic               flush;
  logic               flush_busy;
  logic               mem_req_valid;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_req_ready;
  logic               mem_resp_valid;
  logic [WORD_W-1:0]  mem_resp_data;
  logic               bram_we;
  logic [INDEX_W-1:0] bram_addr;
  logic [LINE_W-1:0]  bram_wdata;
  logic [LINE_W-1:0]  bram_rdata;

  always #5 clk = ~clk;

  icache_ctrl u_dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_req_valid      (req_valid),
    .i_req_addr       (req_addr),
    .o_req_ready      (req_ready),
    .o_resp_valid     (resp_valid),
    .o_resp_data      (resp_data),
    .i_flush          (flush),
    .o_flush_busy     (flush_busy),
    .o_mem_req_valid  (mem_req_valid),
    .o_mem_req_addr   (mem_req_addr),
    .i_mem_req_ready  (mem_req_ready),
    .i_mem_resp_valid (mem_resp_valid),
    .i_mem_resp_data  (mem_resp_data),
    .o_bram_we        (bram_we),
    .o_bram_addr      (bram_addr),
    .o_bram_wdata     (bram_wdata),
    .i_bram_rdata     (bram_rdata)
  );

  // Line RAM: asynchronous read, synchronous write.
  logic [LINE_W-1:0] ram [LINES];
  assign bram_rdata = ram[bram_addr];
  always @(posedge clk) if (bram_we) ram[bram_addr] <= bram_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Backing memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] la, input int k);
    case (la)
      32'h0001_2340: return 32'hA000_0000 + 32'(k);
      32'h0002_2340: return 32'hB000_0000 + 32'(k);
      default:       return (la ^ 32'h5A5A_0000) + 32'(k);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] line_of(input logic [31:0] la);
    logic [DATA_W-1:0] d;
    for (int k = 0; k < WORDS; k++) d[k*32 +: 32] = mem_word(la, k);
    return d;
  endfunction

  // Reference model state.
  bit               m_valid [LINES];
  logic [TAG_W-1:0] m_tag   [LINES];
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q[$];
  logic              exp_mem_req = 1'b0;
  logic [31:0]       exp_mem_addr = '0;
  logic              exp_wr = 1'b0;
  logic [9:0]        exp_w_idx = '0;
  logic [LINE_W-1:0] exp_w_line = '0;

  // Observations for literal pins.
  logic [31:0] last_resp_data = '0;
  logic [31:0] last_mem_addr = '0;
  logic [9:0]  last_w_idx = '0;
  logic [15:0] last_w_tag = '0;
  int          mem_hs_cnt = 0;
  int          resp_cnt = 0;
  int          mem_delay = 0;
  int          beat_no = 0;

  // Memory responder: optional request stall, beats start the cycle after handshake.
  initial begin
    int wcnt;
    int beat;
    bit active;
    logic [31:0] la;
    wcnt = 0; beat = 0; active = 0; la = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (!rst_n) begin
        mem_req_ready = 1'b0; active = 0; wcnt = 0;
      end else begin
        if (mem_req_ready) begin
          mem_req_ready = 1'b0; active = 1; beat = 0;
        end
        if (active) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_word(la, beat);
          beat_no = beat;
          beat++;
          if (beat == WORDS) active = 0;
        end else if (mem_req_valid) begin
          if (wcnt >= mem_delay) begin
            mem_req_ready = 1'b1; la = mem_req_addr; wcnt = 0;
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  // Compare process.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (resp_valid) begin
          resp_cnt++;
          last_resp_data = resp_data;
          chk("resp_expected", 64'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("resp_data", resp_data, e.data);
            chk("resp_cycle", cyc, e.cyc);
          end
        end
        if (mem_req_valid) begin
          chk("mem_req_expected", exp_mem_req, 1);
          chk("mem_req_addr", mem_req_addr, exp_mem_addr);
          if (mem_req_ready) begin
            mem_hs_cnt++;
            last_mem_addr = mem_req_addr;
            exp_mem_req = 1'b0;
          end
        end
        if (bram_we && !flush_busy) begin
          last_w_idx = bram_addr;
          last_w_tag = bram_wdata[TAG_MSB:TAG_LSB];
          chk("write_expected", exp_wr, 1);
          chk("write_idx", bram_addr, exp_w_idx);
          chk("write_line", 64'(bram_wdata == exp_w_line), 1);
          exp_wr = 1'b0;
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input int d, output bit was_miss);
    int t;
    logic [9:0]  idx;
    logic [15:0] tg;
    logic [31:0] la;
    exp_t e;
    idx = a[15:6]; tg = a[31:16]; la = {a[31:6], 6'b0};
    was_miss = 0;
    @(negedge clk); #1;
    req_valid = 1'b1; req_addr = a; mem_delay = d;
    t = 0;
    while (!req_ready && t < 3000) begin
      @(negedge clk); #1; t++;
    end
    chk("req_accepted", req_ready, 1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    was_miss = !(m_valid[idx] && m_tag[idx] == tg);
    e.data = mem_word(la, int'(a[5:2]));
    e.cyc  = cyc + (was_miss ? 20 + d : 1);
    if (was_miss) begin
      exp_mem_req = 1'b1; exp_mem_addr = la;
      exp_wr = 1'b1; exp_w_idx = idx; exp_w_line = {1'b1, tg, line_of(la)};
      m_valid[idx] = 1; m_tag[idx] = tg;
    end
    q.push_back(e);
    @(negedge clk); #1;
    req_valid = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk); t++;
    end
    chk("resp_arrived", q.size(), 0);
    q.delete();
  endtask

  // Measures one full sweep; entry point is #1 after a falling edge.
  task automatic check_sweep(input string name);
    int t, n, bad;
    t = 0;
    while (!flush_busy && t < 50) begin
      @(negedge clk); #1; t++;
    end
    n = 0; bad = 0;
    while (flush_busy && n < 2000) begin
      if (!(bram_we && bram_addr == 10'(n) && bram_wdata == '0 && !req_ready)) bad++;
      n++;
      @(negedge clk); #1;
    end
    chk({name, "_sweep_len"}, n, 1024);
    chk({name, "_sweep_bad_writes"}, bad, 0);
    chk({name, "_ready_after_sweep"}, req_ready, 1);
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
  endtask

  task automatic check_reset_outs(input string p);
    chk({p, "_req_ready"}, req_ready, 0);
    chk({p, "_resp_valid"}, resp_valid, 0);
    chk({p, "_resp_data"}, resp_data, 0);
    chk({p, "_mem_req_valid"}, mem_req_valid, 0);
    chk({p, "_mem_req_addr"}, mem_req_addr, 0);
    chk({p, "_flush_busy"}, flush_busy, 1);
    chk({p, "_bram_we"}, bram_we, 1);
    chk({p, "_bram_addr"}, bram_addr, 0);
    chk({p, "_bram_wdata_zero"}, 64'(bram_wdata == '0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit m;
    int t, h0, r0;
    rst_n = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    for (int i = 0; i < LINES; i++) begin m_valid[i] = 0; m_tag[i] = '0; end
    #2 rst_n = 1'b0;
    #1 check_reset_outs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check_sweep("post_reset");

    // Cold miss.
    h0 = mem_hs_cnt;
    fetch(32'h0001_2344, 0, m);
    chk("cold_model_miss", m, 1);
    chk("cold_mem_hs", mem_hs_cnt - h0, 1);
    chk("cold_mem_addr", last_mem_addr, 32'h0001_2340);
    chk("cold_w_idx", last_w_idx, 10'h08D);
    chk("cold_w_tag", last_w_tag, 16'h0001);
    chk("cold_resp", last_resp_data, 32'hA000_0001);

    // Same-line hits.
    h0 = mem_hs_cnt;
    fetch(32'h0001_2378, 0, m);
    chk("hit_model_hit", m, 0);
    chk("hit_no_mem_req", mem_hs_cnt - h0, 0);
    chk("hit_resp", last_resp_data, 32'hA000_000E);
    @(negedge clk); #1;
    chk("hit_ready_n_plus_2", req_ready, 1);
    fetch(32'h0001_237C, 0, m);
    chk("hit2_resp", last_resp_data, 32'hA000_000F);

    // Conflict miss with a stalled memory request, then the old tag misses again.
    h0 = mem_hs_cnt;
    fetch(32'h0002_2344, 2, m);
    chk("conflict_mem_hs", mem_hs_cnt - h0, 1);
    chk("conflict_w_idx", last_w_idx, 10'h08D);
    chk("conflict_w_tag", last_w_tag, 16'h0002);
    chk("conflict_resp", last_resp_data, 32'hB000_0001);
    h0 = mem_hs_cnt;
    fetch(32'h0001_2344, 0, m);
    chk("refetch_mem_hs", mem_hs_cnt - h0, 1);
    chk("refetch_resp", last_resp_data, 32'hA000_0001);

    // Flush pulse during a refill: refill completes and responds, then the sweep.
    fork
      fetch(32'h0003_0108, 0, m);
      begin
        t = 0;
        do begin
          @(negedge clk); #1; t++;
        end while (!(mem_resp_valid && beat_no == 3) && t < 200);
        flush = 1'b1;
        @(negedge clk); #1;
        flush = 1'b0;
      end
    join
    chk("flush_refill_resp", last_resp_data, mem_word(32'h0003_0100, 2));
    check_sweep("flush");
    h0 = mem_hs_cnt;
    fetch(32'h0003_0108, 0, m);
    chk("post_flush_mem_hs", mem_hs_cnt - h0, 1);

    // Reset at beat 7 of a refill.
    @(negedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h0004_0084; mem_delay = 0;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk); #1; t++;
    end
    chk("rst_test_accepted", req_ready, 1);
    exp_mem_req = 1'b1; exp_mem_addr = 32'h0004_0080;
    r0 = resp_cnt;
    @(negedge clk); #1;
    req_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk); #1; t++;
    end while (!(mem_resp_valid && beat_no == 7) && t < 100);
    chk("rst_test_beat7", beat_no, 7);
    rst_n = 1'b0;
    #1 check_reset_outs("midrefill_reset");
    exp_mem_req = 1'b0; exp_wr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check_sweep("midrefill");
    chk("midrefill_no_resp", resp_cnt, r0);
    fetch(32'h0004_0084, 0, m);
    chk("midrefill_refetch_resp", last_resp_data, mem_word(32'h0004_0080, 1));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
